reg_write_scheduler: RTL and testbench

//   Shares the single write port of Reg_Block (Addr_In/Data_In/WE) among NUM_REQ requesters.

---
 rtl/reg_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/reg_write_scheduler.sv | 103 ++++++++++
 tb/tb_reg_write_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Defaults shared with Reg_Block and the write-scheduler state encoding.
package reg_pkg;

    localparam int unsigned REG_ADDR_W = 8;
    localparam int unsigned REG_DATA_W = 16;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef enum logic [0:0] {
        ARB   = ST_ARB,
        CLEAR = ST_CLEAR
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_win;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_win   = r_last;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((32'(r_last) + k) % NUM_REQ);
            if (i_en && !w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_win          = w_idx;
                w_found        = 1'b1;
            end
        end
    end

    // Reset parks the pointer on the last index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_last <= w_win;
        end
    end

endmodule

// File: rtl/reg_write_scheduler.sv
// Shares the Reg_Block write port among NUM_REQ requesters; includes a clear sequencer.
module reg_write_scheduler
    import reg_pkg::*;
#(
    parameter int unsigned         NUM_REQ        = 4,
    parameter int unsigned         ADDR_W         = REG_ADDR_W,
    parameter int unsigned         DATA_W         = REG_DATA_W,
    parameter logic [DATA_W-1:0]   CLEAR_VALUE    = '0,
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*ADDR_W-1:0] Req_Addr,
    input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
    output logic [NUM_REQ-1:0]        Grant,
    input  logic                      Clear_Start,
    output logic                      Clear_Busy,
    output logic [ADDR_W-1:0]         Addr_In,
    output logic [DATA_W-1:0]         Data_In,
    output logic                      WE
);

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_we;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_arb_en;
    logic              w_xfer;
    logic [ADDR_W:0]   w_cnt_next;
    logic              w_last_clear;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    // Clear_Start blocks grants in its own cycle so no transfer races the clear entry.
    assign w_arb_en = (r_state == ST_ARB) && !Clear_Start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_arb_en),
        .i_req   (Req),
        .o_grant (Grant)
    );

    assign w_xfer       = |Grant;
    assign w_cnt_next   = r_cnt + 1'b1;
    assign w_last_clear = w_cnt_next[ADDR_W];

    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (Grant[i]) begin
                w_win_addr = w_win_addr | Req_Addr[i*ADDR_W +: ADDR_W];
                w_win_data = w_win_data | Req_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_we   <= 1'b1;
            r_busy <= 1'b1;
            r_addr <= r_cnt[ADDR_W-1:0];
            r_data <= CLEAR_VALUE;
            if (w_last_clear) begin
                r_state <= ST_ARB;
                r_cnt   <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end else begin
            r_busy <= 1'b0;
            r_we   <= w_xfer;
            if (w_xfer) begin
                r_addr <= w_win_addr;
                r_data <= w_win_data;
            end
            if (Clear_Start) begin
                r_state <= ST_CLEAR;
            end
        end
    end

    assign WE         = r_we;
    assign Addr_In    = r_addr;
    assign Data_In    = r_data;
    assign Clear_Busy = r_busy;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler with a behavioural Reg_Block behind it.
module tb_reg_write_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     Req = '0;
    logic [NR*AW-1:0]  Req_Addr = '0;
    logic [NR*DW-1:0]  Req_Data = '0;
    logic [NR-1:0]     Grant;
    logic              Clear_Start = 1'b0;
    logic              Clear_Busy;
    logic [AW-1:0]     Addr_In;
    logic [DW-1:0]     Data_In;
    logic              WE;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] q_addr [NR];
    logic [DW-1:0] q_data [NR];
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] rb [0:255];
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;

    reg_write_scheduler #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .CLEAR_VALUE    (16'h0000),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Req         (Req),
        .Req_Addr    (Req_Addr),
        .Req_Data    (Req_Data),
        .Grant       (Grant),
        .Clear_Start (Clear_Start),
        .Clear_Busy  (Clear_Busy),
        .Addr_In     (Addr_In),
        .Data_In     (Data_In),
        .WE          (WE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (WE) rb[Addr_In] <= Data_In;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        q_addr[i] = a;
        q_data[i] = d;
        Req_Addr[i*AW +: AW] = a;
        Req_Data[i*DW +: DW] = d;
    endtask

    // Grant checked mid-cycle; registered outputs checked just after the edge.
    task automatic tick(input logic [NR-1:0] eg, input exp_t e_in, input string tag);
        exp_t e;
        sb.push_back(e_in);
        @(negedge clk);
        chk({tag, ".grant"}, 32'(Grant), 32'(eg));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".we"},   32'(WE),         32'(e.we));
        chk({tag, ".addr"}, 32'(Addr_In),    32'(e.addr));
        chk({tag, ".data"}, 32'(Data_In),    32'(e.data));
        chk({tag, ".busy"}, 32'(Clear_Busy), 32'(e.busy));
    endtask

    task automatic arb_tick(input logic [NR-1:0] eg, input string tag);
        exp_t e;
        e = '{we: 1'b0, addr: m_addr, data: m_data, busy: 1'b0};
        for (int i = 0; i < NR; i++) begin
            if (eg[i]) begin
                e.we   = 1'b1;
                e.addr = q_addr[i];
                e.data = q_data[i];
            end
        end
        m_addr = e.addr;
        m_data = e.data;
        tick(eg, e, tag);
    endtask

    task automatic clr_tick(input int i, input string tag);
        exp_t e;
        e = '{we: 1'b1, addr: AW'(i), data: 16'h0000, busy: 1'b1};
        m_addr = AW'(i);
        m_data = 16'h0000;
        tick('0, e, tag);
    endtask

    task automatic rst_tick(input string tag);
        m_addr = '0;
        m_data = '0;
        tick('0, '{we: 1'b0, addr: '0, data: '0, busy: 1'b0}, tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        chk(tag, 32'(rb[a]), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < NR; i++) set_req(i, '0, '0);

        // Power-on: first edge brings state out of X, second reset edge is checked.
        @(posedge clk);
        #1;
        rst_tick("reset");
        rst = 1'b0;
        for (int i = 0; i < 256; i++) clr_tick(i, "t1.clear");
        arb_tick(4'b0000, "t1.exit");
        rd(8'd10, 16'd0, "t1.rd10");

        set_req(0, 8'd10, 16'd4);
        Req = 4'b0001;
        arb_tick(4'b0001, "t2.single");
        Req = 4'b0000;
        arb_tick(4'b0000, "t2.idle");
        rd(8'd10, 16'd4, "t2.rd10");

        set_req(1, 8'd15, 16'd9);
        Req = 4'b0010;
        Clear_Start = 1'b1;
        arb_tick(4'b0000, "t5.entry");
        Clear_Start = 1'b0;
        for (int i = 0; i < 256; i++) clr_tick(i, "t5.clear");
        arb_tick(4'b0010, "t5.served");
        Req = 4'b0000;
        arb_tick(4'b0000, "t5.idle");
        rd(8'd15, 16'd9, "t5.rd15");
        rd(8'd10, 16'd0, "t5.rd10");

        Clear_Start = 1'b1;
        arb_tick(4'b0000, "t6.entry");
        Clear_Start = 1'b0;
        for (int i = 0; i <= 100; i++) clr_tick(i, "t6.clear");
        rst = 1'b1;
        rst_tick("t6.abort");
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            Clear_Start = (i == 50);
            clr_tick(i, "t6.restart");
        end
        Clear_Start = 1'b0;
        arb_tick(4'b0000, "t6.exit");

        set_req(0, 8'd20, 16'h0021);
        set_req(2, 8'd22, 16'h0023);
        Req = 4'b0101;
        arb_tick(4'b0001, "t4.g0");
        Req = 4'b0100;
        arb_tick(4'b0100, "t4.g2a");
        arb_tick(4'b0100, "t4.g2b");
        set_req(3, 8'd30, 16'h0031);
        Req = 4'b1000;
        arb_tick(4'b1000, "t4.g3");

        for (int i = 0; i < NR; i++) set_req(i, AW'(11 + i), DW'(5 + i));
        Req = 4'b1111;
        arb_tick(4'b0001, "t3.g0");
        arb_tick(4'b0010, "t3.g1");
        arb_tick(4'b0100, "t3.g2");
        arb_tick(4'b1000, "t3.g3");
        arb_tick(4'b0001, "t3.g0b");
        Req = 4'b0000;
        arb_tick(4'b0000, "t3.idle");
        rd(8'd11, 16'd5, "t3.rd11");
        rd(8'd12, 16'd6, "t3.rd12");
        rd(8'd13, 16'd7, "t3.rd13");
        rd(8'd14, 16'd8, "t3.rd14");
        rd(8'd20, 16'h0021, "t4.rd20");
        rd(8'd22, 16'h0023, "t4.rd22");
        rd(8'd30, 16'h0031, "t4.rd30");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
